// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: VALID/READY byte intake, baud timing and LSB-first
// serialisation of start / data / stop bits onto TXD.
module uart_tx_ctrl #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 R_N,
  input  logic [DATA_BITS-1:0] DIN,
  input  logic                 VALID,
  output logic                 READY,
  output logic                 TXD,
  output logic                 BUSY
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_idx;
  logic                 tick;
  logic                 last_stop;

  assign tick      = (cnt == CNT_MAX);
  // A single stop bit always ends on its first tick; two stop bits need the second.
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (VALID) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bit_idx == BIT_MAX) state_nxt = STOP;
      STOP:    if (tick && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      stop_idx <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      if (state == IDLE && VALID)     shift <= DIN;
      else if (state == DATA && tick) shift <= shift >> 1;

      // Saturates at the last data bit so it can never wrap into a bogus index.
      if (state == START && tick)
        bit_idx <= '0;
      else if (state == DATA && tick && bit_idx != BIT_MAX)
        bit_idx <= bit_idx + 1'b1;

      if (state != STOP) stop_idx <= 1'b0;
      else if (tick)     stop_idx <= ~stop_idx;
    end
  end

  always_comb begin
    TXD = 1'b1;
    case (state)
      START:   TXD = 1'b0;
      DATA:    TXD = shift[0];
      default: TXD = 1'b1;
    endcase
  end

  assign READY = (state == IDLE);
  assign BUSY  = ~READY;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table of frames, hand-written corner sequences, and a
// randomized run against a frame-level reference model.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       R_N = 1'b0;
  logic [7:0] DIN = '0;
  logic       VALID = 1'b0;
  logic       READY, TXD, BUSY;

  logic [4:0] DIN2 = '0;
  logic       VALID2 = 1'b0;
  logic       READY2, TXD2, BUSY2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_ctrl #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .CLK(CLK), .R_N(R_N), .DIN(DIN), .VALID(VALID),
    .READY(READY), .TXD(TXD), .BUSY(BUSY)
  );

  uart_tx_ctrl #(.CLK_DIV(3), .DATA_BITS(5), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .R_N(R_N), .DIN(DIN2), .VALID(VALID2),
    .READY(READY2), .TXD(TXD2), .BUSY(BUSY2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] din;
    logic [9:0] line;     // expected TXD level per bit slot, slot 0 first
    logic       disturb;  // poke DIN/VALID mid-frame
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Line level of bit slot j of a frame: start, data LSB first, then stop.
  function automatic logic frame_bit(input logic [7:0] b, input int dbits, input int j);
    if (j == 0)          return 1'b0;
    else if (j <= dbits) return b[j-1];
    else                 return 1'b1;
  endfunction

  task automatic send_check(input logic [7:0] din, input logic [9:0] line, input logic disturb);
    DIN = din;
    VALID = 1'b1;
    step();
    VALID = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      chk("frame_txd", TXD, line[k/4]);
      chk("frame_ready", READY, 0);
      chk("frame_busy", BUSY, 1);
      if (disturb && k == 17) begin DIN = 8'hFF; VALID = 1'b1; end
      if (disturb && k == 19) VALID = 1'b0;
    end
    step();
    chk("frame_end_ready", READY, 1);
    chk("frame_end_busy", BUSY, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("no_extra_frame_txd", TXD, 1);
      chk("no_extra_frame_ready", READY, 1);
    end
  endtask

  initial begin
    vec_t tbl[5];
    logic       prev, found, m_busy, v;
    int         t0, t1, idle_cnt, m_t;
    logic [7:0] m_byte, d;
    logic [9:0] ff_line;

    tbl[0] = '{din: 8'hA5, line: 10'h34A, disturb: 1'b0};
    tbl[1] = '{din: 8'hA5, line: 10'h34A, disturb: 1'b1};
    tbl[2] = '{din: 8'h00, line: 10'h200, disturb: 1'b0};
    tbl[3] = '{din: 8'h01, line: 10'h202, disturb: 1'b0};
    tbl[4] = '{din: 8'h80, line: 10'h300, disturb: 1'b1};

    // Reset held with VALID asserted: nothing may start.
    R_N = 1'b0; VALID = 1'b1; DIN = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_txd", TXD, 1);
      chk("reset_ready", READY, 1);
      chk("reset_busy", BUSY, 0);
    end
    R_N = 1'b1;
    step();
    chk("first_handshake_txd", TXD, 0);
    chk("first_handshake_ready", READY, 0);
    VALID = 1'b0;
    for (int i = 0; i < 39; i++) step();
    step();
    chk("post_reset_frame_end", READY, 1);

    for (int i = 0; i < 5; i++) send_check(tbl[i].din, tbl[i].line, tbl[i].disturb);

    // Back-to-back with VALID held high.
    DIN = 8'h00; VALID = 1'b1;
    step();
    t0 = cyc;
    chk("b2b_start0", TXD, 0);
    DIN = 8'hFF;
    found = 1'b0; idle_cnt = 0; t1 = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      prev = READY;
      step();
      if (READY) begin
        idle_cnt++;
        chk("b2b_gap_txd", TXD, 1);
      end
      if (prev && !READY) begin found = 1'b1; t1 = cyc; end
    end
    VALID = 1'b0;
    chk("b2b_found", found, 1);
    chk("b2b_spacing", t1 - t0, 41);
    chk("b2b_idle_cycles", idle_cnt, 1);
    ff_line = 10'h3FE;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      chk("b2b_frame2_txd", TXD, ff_line[k/4]);
    end
    step();
    chk("b2b_end_ready", READY, 1);

    // Reset during data bit 3 of 8'hA5, then a clean 8'h3C frame.
    DIN = 8'hA5; VALID = 1'b1;
    step();
    VALID = 1'b0;
    for (int k = 1; k <= 17; k++) step();
    chk("midreset_bit3_low", TXD, 0);
    R_N = 1'b0;
    #1;
    chk("midreset_txd", TXD, 1);
    chk("midreset_ready", READY, 1);
    chk("midreset_busy", BUSY, 0);
    step();
    step();
    R_N = 1'b1;
    send_check(8'h3C, 10'h278, 1'b0);

    // DATA_BITS=5, STOP_BITS=2, CLK_DIV=3 instance.
    DIN2 = 5'h0B; VALID2 = 1'b1;
    step();
    VALID2 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      chk("sweep_txd", TXD2, frame_bit(8'h0B, 5, k / 3));
      chk("sweep_ready", READY2, 0);
      chk("sweep_bitidx_max", dut2.bit_idx <= 3'd4, 1);
      if (k >= 18) chk("sweep_bitidx_sat", dut2.bit_idx, 4);
    end
    step();
    chk("sweep_end_ready", READY2, 1);
    chk("sweep_end_txd", TXD2, 1);

    // Randomized traffic against a frame-level model.
    m_busy = 1'b0; m_t = 0; m_byte = '0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      VALID = v;
      DIN = d;
      step();
      if (!m_busy) begin
        if (v) begin m_busy = 1'b1; m_t = 0; m_byte = d; end
      end else begin
        m_t++;
        if (m_t == 40) m_busy = 1'b0;
      end
      chk("rand_ready", READY, !m_busy);
      chk("rand_busy", BUSY, m_busy);
      chk("rand_txd", TXD, m_busy ? frame_bit(m_byte, 8, m_t / 4) : 1'b1);
    end
    VALID = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
